fpu_share_arb: RTL and testbench

Two-requester arbiter and issue sequencer for the shared single-precision FPU pipeline and its exception-detection stage. It accepts operations from two clients over valid/ready handshakes and grants them round-robin. It issues one operation per cycle into the fixed-latency FPU and tracks in-flight ownership with a tag pipeline, so each result and its exception flags return to the correct requester. A quiesce/drain FSM lets the rest of the design halt the FPU cleanly.

---
 rtl/fpu_share_arb_if.sv | 26 ++
 rtl/fpu_share_arb.sv | 198 +++++++++++++++++++
 tb/tb_fpu_share_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_share_arb_if.sv
// fpu_share_arb_if: client-side request/response bus of the shared-FPU arbiter.
// Requester i occupies bit i of the valid/ready/rsp_valid vectors and slice i of the
// packed operand fields (op [i*3+:3], rmode [i*2+:2], opa/opb [i*32+:32]).
interface fpu_share_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [3:0]  req_rmode;
    logic [63:0] req_opa;
    logic [63:0] req_opb;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_exc;

    // Requester side
    modport master (
        output req_valid, req_op, req_rmode, req_opa, req_opb,
        input  req_ready, rsp_valid, rsp_result, rsp_exc
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_rmode, req_opa, req_opb,
        output req_ready, rsp_valid, rsp_result, rsp_exc
    );
endinterface

// File: rtl/fpu_share_arb.sv
// fpu_share_arb: two-requester round-robin arbiter and issue sequencer for a shared
// fixed-latency FPU. A {valid, id} tag pipeline follows each op through the FPU so the
// result is steered back to its owner. RUN/DRAIN/HALT FSM lets the system quiesce the FPU.
// Optional feature: define FPU_ARB_STICKY_EXC_EN to build per-requester sticky exception
// flags; without it sticky_exc is tied to 0 and sticky_clr is ignored.

// Per-requester bookkeeping: outstanding-op counter, eligibility and sticky flags.
module fpu_share_arb_lane #(
    parameter int MAX_OUT = 2,
    parameter int CW      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       grant,
    input  logic       rsp,
    input  logic [4:0] exc,
    input  logic       clr,
    output logic       eligible,
    output logic [4:0] sticky
);
    logic [CW-1:0] cnt;

    // A response retiring this cycle frees its slot at once, allowing a same-cycle regrant.
    assign eligible = run && ((cnt < CW'(MAX_OUT)) || rsp);

    // Outstanding ops: up on grant, down on response, unchanged when both coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (grant && !rsp)  cnt <= cnt + CW'(1);
        else if (!grant && rsp)  cnt <= cnt - CW'(1);
    end

`ifdef FPU_ARB_STICKY_EXC_EN
    logic [4:0] flags;

    // Accumulate exception flags per response; a clear in the same cycle drops only the old flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     flags <= '0;
        else if (rsp)   flags <= clr ? exc : (flags | exc);
        else if (clr)   flags <= '0;
    end

    assign sticky = flags;
`else
    logic unused_sticky_in;
    assign unused_sticky_in = ^{exc, clr};
    assign sticky = '0;
`endif
endmodule

module fpu_share_arb #(
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpu_share_arb_if.slave        client,
    output logic                  fpu_start,
    output logic [2:0]            fpu_op,
    output logic [1:0]            fpu_rmode,
    output logic [31:0]           fpu_opa,
    output logic [31:0]           fpu_opb,
    input  logic [31:0]           fpu_out,
    input  logic [4:0]            fpu_exc,
    input  logic                  quiesce,
    output logic                  idle,
    output logic [9:0]            sticky_exc,
    input  logic [1:0]            sticky_clr
);
    localparam int NUM_REQ = 2;
    localparam int CW      = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  rmode;
        logic [31:0] opa;
        logic [31:0] opb;
    } issue_t;

    state_t               state, state_nxt;
    logic                 live;       // low for the first cycle after reset so ready stays 0
    logic                 last;       // requester granted most recently
    logic                 run;
    logic                 drained;
    logic [NUM_REQ-1:0]   eligible, want, grant, rsp_valid;
    logic [LATENCY:0]     vld_pipe;
    logic [LATENCY:0]     id_pipe;
    issue_t [NUM_REQ-1:0] slot;
    issue_t               sel, issue_q;

    // Hold grants off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    assign run  = live && (state == RUN);
    assign want = client.req_valid & eligible;

    // Round-robin: a lone eligible requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant = '0;
        if (want == 2'b11) grant = last ? 2'b01 : 2'b10;
        else               grant = want;
    end

    assign client.req_ready = grant;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_req
            assign slot[g] = {client.req_op[g*3 +: 3], client.req_rmode[g*2 +: 2],
                              client.req_opa[g*32 +: 32], client.req_opb[g*32 +: 32]};

            fpu_share_arb_lane #(
                .MAX_OUT (MAX_OUT),
                .CW      (CW)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .run      (run),
                .grant    (grant[g]),
                .rsp      (rsp_valid[g]),
                .exc      (fpu_exc),
                .clr      (sticky_clr[g]),
                .eligible (eligible[g]),
                .sticky   (sticky_exc[g*5 +: 5])
            );
        end
    endgenerate

    assign sel = grant[1] ? slot[1] : slot[0];

    // Pointer moves only on an actual handshake; reset state makes requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= 1'b1;
        else if (|grant) last <= grant[1];
    end

    // Issue register: capture the winner's operands and strobe the FPU one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_start <= 1'b0;
            issue_q   <= '0;
        end else begin
            fpu_start <= |grant;
            if (|grant) issue_q <= sel;
        end
    end

    assign fpu_op    = issue_q.op;
    assign fpu_rmode = issue_q.rmode;
    assign fpu_opa   = issue_q.opa;
    assign fpu_opb   = issue_q.opb;

    // Ownership tags: stage 0 lines up with fpu_start, stage LATENCY with fpu_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], |grant};
            id_pipe  <= {id_pipe[LATENCY-1:0], grant[1]};
        end
    end

    assign rsp_valid[0]      = vld_pipe[LATENCY] & ~id_pipe[LATENCY];
    assign rsp_valid[1]      = vld_pipe[LATENCY] &  id_pipe[LATENCY];
    assign client.rsp_valid  = rsp_valid;
    assign client.rsp_result = fpu_out;
    assign client.rsp_exc    = fpu_exc;

    // Only the head may still be busy: it retires this cycle, so HALT follows the last response.
    assign drained = ~|vld_pipe[LATENCY-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // FSM next state: dropping quiesce always returns to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (quiesce) state_nxt = DRAIN;
            DRAIN:   if (!quiesce)    state_nxt = RUN;
                     else if (drained) state_nxt = HALT;
            HALT:    if (!quiesce) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign idle = (state == HALT);
endmodule

// File: tb/tb_fpu_share_arb.sv
// tb_fpu_share_arb: randomized bench with a transaction-level reference model and a
// response scoreboard. A stub FPU returns a deterministic function of the issued operands
// LATENCY cycles after fpu_start and drives random garbage otherwise.
module tb_fpu_share_arb;
    localparam int LATENCY = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [31:0] fpu_opa, fpu_opb;
    logic [31:0] fpu_out = '0;
    logic [4:0]  fpu_exc = '0;
    logic        quiesce = 1'b0;
    logic        idle;
    logic [9:0]  sticky_exc;
    logic [1:0]  sticky_clr = '0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    fpu_share_arb_if bus();

    fpu_share_arb #(.LATENCY(LATENCY), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .client     (bus),
        .fpu_start  (fpu_start),
        .fpu_op     (fpu_op),
        .fpu_rmode  (fpu_rmode),
        .fpu_opa    (fpu_opa),
        .fpu_opb    (fpu_opb),
        .fpu_out    (fpu_out),
        .fpu_exc    (fpu_exc),
        .quiesce    (quiesce),
        .idle       (idle),
        .sticky_exc (sticky_exc),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endfunction

    // Stand-in FPU arithmetic: {exc, result}.
    function automatic logic [36:0] fref(input logic [2:0] op, input logic [1:0] rm,
                                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  e;
        r = (a ^ {b[15:0], b[31:16]}) + {27'd0, op, rm};
        e = a[4:0] ^ b[9:5] ^ {op, rm};
        return {e, r};
    endfunction

    // Stub FPU: record what was issued each cycle, replay it LATENCY cycles later.
    typedef struct packed { logic vld; logic [36:0] er; } ring_t;
    ring_t ring [32];

    initial begin
        for (int k = 0; k < 32; k++) ring[k] = '0;
        forever begin
            @(negedge clk);
            ring[cyc % 32] = {fpu_start, fref(fpu_op, fpu_rmode, fpu_opa, fpu_opb)};
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (cyc >= LATENCY && ring[(cyc - LATENCY) % 32].vld)
                {fpu_exc, fpu_out} = ring[(cyc - LATENCY) % 32].er;
            else begin
                fpu_out = $urandom;
                fpu_exc = 5'($urandom);
            end
        end
    end

    // Scoreboard of expected responses, in issue order.
    typedef struct { logic id; logic [31:0] res; logic [4:0] exc; int due; } sb_t;
    sb_t sb[$];

    // Reference model: per-requester list of in-flight ops (their count is the outstanding count).
    typedef struct { int due; logic [4:0] exc; } pend_t;
    pend_t pend0[$], pend1[$];
    int          m_state = 0;      // 0 RUN, 1 DRAIN, 2 HALT
    int          m_tie = 0;        // who wins the next tie
    bit          m_live = 0;
    bit          prev_hs = 0;
    logic [68:0] prev_pkt = '0;
    logic [9:0]  m_sticky = '0;

    initial begin
        logic [1:0]  due_now, elig, want, exp_rdy;
        logic [36:0] er;
        int          w;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_fpu_start", fpu_start, 0);
                chk("rst_fpu_op_opa", {fpu_op, fpu_rmode, fpu_opa}, 0);
                chk("rst_fpu_opb", fpu_opb, 0);
                chk("rst_idle", idle, 0);
                chk("rst_sticky", sticky_exc, 0);
                pend0.delete(); pend1.delete();
                m_state = 0; m_tie = 0; m_live = 0; prev_hs = 0; m_sticky = '0;
            end else begin
                chk("fpu_start", fpu_start, prev_hs);
                if (prev_hs) begin
                    chk("fpu_opa_opb", {fpu_opa, fpu_opb}, prev_pkt[63:0]);
                    chk("fpu_op_rmode", {fpu_op, fpu_rmode}, prev_pkt[68:64]);
                end
                chk("idle", idle, m_state == 2);
                chk("sticky_exc", sticky_exc, m_sticky);

                due_now[0] = pend0.size() > 0 && pend0[0].due == cyc;
                due_now[1] = pend1.size() > 0 && pend1[0].due == cyc;
                elig[0] = m_live && m_state == 0 && (pend0.size() < MAX_OUT || due_now[0]);
                elig[1] = m_live && m_state == 0 && (pend1.size() < MAX_OUT || due_now[1]);
                want = bus.req_valid & elig;
                exp_rdy = '0;
                if (want == 2'b11) exp_rdy[m_tie] = 1'b1;
                else               exp_rdy = want;
                chk("req_ready", bus.req_ready, exp_rdy);

                prev_hs = |exp_rdy;
                if (prev_hs) begin
                    w = exp_rdy[1] ? 1 : 0;
                    prev_pkt = {bus.req_op[w*3 +: 3], bus.req_rmode[w*2 +: 2],
                                bus.req_opa[w*32 +: 32], bus.req_opb[w*32 +: 32]};
                    er = fref(prev_pkt[68:66], prev_pkt[65:64], prev_pkt[63:32], prev_pkt[31:0]);
                    sb.push_back('{id: w[0], res: er[31:0], exc: er[36:32], due: cyc + 1 + LATENCY});
                    if (w == 0) pend0.push_back('{due: cyc + 1 + LATENCY, exc: er[36:32]});
                    else        pend1.push_back('{due: cyc + 1 + LATENCY, exc: er[36:32]});
                    m_tie = 1 - w;
                end

`ifdef FPU_ARB_STICKY_EXC_EN
                if (due_now[0]) m_sticky[4:0] = sticky_clr[0] ? pend0[0].exc : (m_sticky[4:0] | pend0[0].exc);
                else if (sticky_clr[0]) m_sticky[4:0] = '0;
                if (due_now[1]) m_sticky[9:5] = sticky_clr[1] ? pend1[0].exc : (m_sticky[9:5] | pend1[0].exc);
                else if (sticky_clr[1]) m_sticky[9:5] = '0;
`endif
                if (due_now[0]) void'(pend0.pop_front());
                if (due_now[1]) void'(pend1.pop_front());

                case (m_state)
                    0: if (quiesce) m_state = 1;
                    1: if (!quiesce) m_state = 0;
                       else if (pend0.size() == 0 && pend1.size() == 0) m_state = 2;
                    default: if (!quiesce) m_state = 0;
                endcase
                m_live = 1;
            end
        end
    end

    // Monitor: compare every cycle's response port against the scoreboard head.
    initial begin
        sb_t se;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                chk("rst_rsp_valid", bus.rsp_valid, 0);
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                se = sb.pop_front();
                chk("rsp_valid", bus.rsp_valid, se.id ? 2'b10 : 2'b01);
                chk("rsp_result", bus.rsp_result, se.res);
                chk("rsp_exc", bus.rsp_exc, se.exc);
            end else begin
                chk("rsp_quiet", bus.rsp_valid, 0);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic q);
        @(posedge clk); #1;
        bus.req_valid = v;
        bus.req_op    = 6'($urandom);
        bus.req_rmode = 4'($urandom);
        bus.req_opa   = {$urandom, $urandom};
        bus.req_opb   = {$urandom, $urandom};
        quiesce       = q;
        sticky_clr    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
    endtask

    initial begin
        logic q;
        bus.req_valid = '0; bus.req_op = '0; bus.req_rmode = '0;
        bus.req_opa = '0; bus.req_opb = '0;
        q = 1'b0;

        repeat (3) drive(2'b00, 1'b0);
        rst_n = 1'b1;
        while (cyc < 9) drive(2'b00, 1'b0);

        // Single known op from requester 0 at cycle 10.
        drive(2'b01, 1'b0);
        bus.req_op[2:0] = 3'd0;
        bus.req_opa[31:0] = 32'h3F80_0000;
        bus.req_opb[31:0] = 32'h4000_0000;
        repeat (8) drive(2'b00, 1'b0);

        // Both requesters saturating: alternation and back-to-back issue.
        repeat (20) drive(2'b11, 1'b0);
        repeat (8) drive(2'b00, 1'b0);

        // Requester 0 alone: MAX_OUT limit and same-cycle regrant.
        repeat (20) drive(2'b01, 1'b0);
        repeat (8) drive(2'b00, 1'b0);

        // Three ops in flight, then quiesce, then resume.
        drive(2'b01, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b01, 1'b0);
        repeat (12) drive(2'($urandom), 1'b1);
        repeat (4) drive(2'b11, 1'b0);

        // Random traffic with occasional quiesce episodes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) q = ~q;
            drive(2'($urandom), q);
        end
        repeat (2) drive(2'b00, 1'b0);

        // Reset with ops in flight: dropped ops must never respond.
        repeat (3) drive(2'b11, 1'b0);
        drive(2'b00, 1'b0);
        rst_n = 1'b0;
        repeat (2) drive(2'b00, 1'b0);
        rst_n = 1'b1;
        repeat (8) drive(2'b00, 1'b0);
        repeat (3) drive(2'b01, 1'b0);
        repeat (12) drive(2'b00, 1'b0);

        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
